// File: rtl/vga_scan_out.sv
// VGA timing generator and pixel scan-out stage fed from the pixel FIFO.
// Optional VGA_UNDERFLOW_CNT_EN adds a saturating missed-pixel counter output.
module vga_scan_out #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_data,
  output logic        fifo_rd_en,
  input  logic        underflow_clr,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        frame_start,
  output logic        underflow
`ifdef VGA_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam logic [10:0] H_LAST      = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST      = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_ACT       = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT       = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        act;
  logic        act_s1_q, act_s1_d, pop_s1_q, pop_s1_d, miss_s1_q, miss_s1_d;
  logic        hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, first_s1_q, first_s1_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic        frame_start_q, frame_start_d, underflow_q, underflow_d;
`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
`endif

  // FIFO handshake: a pop happens in any cycle where fifo_rd_en is high (only
  // possible when fifo_empty is low); the popped word is on fifo_data the
  // following cycle. There is no retry: a pixel that finds the FIFO empty is lost.
  always_comb begin
    act        = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    fifo_rd_en = rst && act && !fifo_empty;

    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end

    act_s1_d   = act;
    pop_s1_d   = act && !fifo_empty;
    miss_s1_d  = act && fifo_empty;
    hs_s1_d    = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    vs_s1_d    = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);
    first_s1_d = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Stage 2 consumes fifo_data in the cycle it becomes valid after the pop.
    rgb_d = '0;
    if (pop_s1_q) begin
      rgb_d = fifo_data;
    end else if (miss_s1_q) begin
      rgb_d = FILL_COLOR;
    end
    hs_d          = hs_s1_q ? SYNC_POL : !SYNC_POL;
    vs_d          = vs_s1_q ? SYNC_POL : !SYNC_POL;
    blank_n_d     = act_s1_q;
    frame_start_d = first_s1_q;
    underflow_d   = miss_s1_q || (underflow_q && !underflow_clr);

`ifdef VGA_UNDERFLOW_CNT_EN
    ucnt_d = ucnt_q;
    if (underflow_clr) begin
      ucnt_d = {15'd0, miss_s1_q};
    end else if (miss_s1_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
`endif
  end

  // Reset parks the raster at the start of the vertical front porch so the
  // upstream gets a full vertical blanking interval to fill the FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= V_ACT;
      act_s1_q      <= 1'b0;
      pop_s1_q      <= 1'b0;
      miss_s1_q     <= 1'b0;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      first_s1_q    <= 1'b0;
      rgb_q         <= '0;
      hs_q          <= !SYNC_POL;
      vs_q          <= !SYNC_POL;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
`ifdef VGA_UNDERFLOW_CNT_EN
      ucnt_q        <= '0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      act_s1_q      <= act_s1_d;
      pop_s1_q      <= pop_s1_d;
      miss_s1_q     <= miss_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      first_s1_q    <= first_s1_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
`ifdef VGA_UNDERFLOW_CNT_EN
      ucnt_q        <= ucnt_d;
`endif
    end
  end

  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
`ifdef VGA_UNDERFLOW_CNT_EN
  assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a reduced 15x8 raster (8x4 active), SYNC_POL=0.
// Expected values come from a raster/scoreboard model and hand-computed vectors.
module tb_vga_scan_out;

  localparam logic [23:0] FILL = 24'hABCDEF;
  localparam logic [27:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty = 1'b0;
  logic [23:0] fifo_data = 24'h0;
  logic        fifo_rd_en;
  logic        underflow_clr = 1'b0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start, underflow;
`ifdef VGA_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  int checks = 0;
  int failures = 0;

  vga_scan_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .FILL_COLOR(FILL)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .underflow_clr(underflow_clr),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .frame_start(frame_start), .underflow(underflow)
`ifdef VGA_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [23:0] pix_of(int n);
    logic [7:0] r, g, b;
    r = 8'h12 + 8'(n);
    g = 8'h34 + 8'(2 * n);
    b = 8'h56 + 8'(3 * n);
    return {r, g, b};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- raster model (advances on posedge) ----------------
  int          mh = 0, mv = 4, cyc = 0;
  logic        uf_m = 1'b0, miss_m1 = 1'b0;
  logic [15:0] cnt_m = 16'd0;

  function automatic logic model_act();
    return (mh < 8) && (mv < 4);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mh = 0; mv = 4; cyc = 0; uf_m = 1'b0; miss_m1 = 1'b0; cnt_m = 16'd0;
    end else begin
      uf_m = miss_m1 || (uf_m && !underflow_clr);
      if (underflow_clr) cnt_m = {15'd0, miss_m1};
      else if (miss_m1 && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      miss_m1 = model_act() && fifo_empty;
      if (mh == 14) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      cyc++;
    end
  end

  // ---------------- scoreboard (samples on negedge) ----------------
  logic [27:0] exp_q[$];
  logic [27:0] e, v;
  logic        rd_seen = 1'b0;
  int          exp_pops = 0, dut_pops = 0;

  always @(negedge clk) begin
    chk("rd_en", 64'(fifo_rd_en), 64'(rst && model_act() && !fifo_empty));
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      chk("out_vec", 64'({vga_hs, vga_vs, vga_blank_n, frame_start, vga_r, vga_g, vga_b}), 64'(e));
    end
    chk("underflow", 64'(underflow), 64'(uf_m));
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("underflow_cnt", 64'(underflow_cnt), 64'(cnt_m));
`endif
    if (!rst) begin
      exp_q.delete();
      exp_q.push_back(RST_VEC);
      exp_q.push_back(RST_VEC);
    end else begin
      v[27]    = !((mh >= 10) && (mh < 13));
      v[26]    = !((mv >= 5) && (mv < 7));
      v[25]    = model_act();
      v[24]    = (mh == 0) && (mv == 0);
      v[23:0]  = 24'h0;
      if (model_act()) begin
        if (fifo_empty) v[23:0] = FILL;
        else begin
          v[23:0] = pix_of(exp_pops);
          exp_pops++;
        end
      end
      exp_q.push_back(v);
    end
    rd_seen = fifo_rd_en;
    if (fifo_rd_en) dut_pops++;
  end

  // ---------------- FIFO read-data driver ----------------
  initial begin : fifo_driver
    int data_idx;
    data_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen) begin
        fifo_data = pix_of(data_idx);
        data_idx++;
      end else begin
        fifo_data = 24'hBADBAD;
      end
    end
  end

  // ---------------- sequencing tasks ----------------
  task automatic wait_cyc(input int k);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (cyc == k) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("wait_cyc_timeout", 64'(hit), 64'd1);
  endtask

  task automatic at_cyc(input int k);
    wait_cyc(k);
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          k;
    logic        rd;
    logic        blank_n;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl[18];
  int   snap[18];
  int   pops_at_rel;

  initial begin
    tbl[0]  = '{0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[1]  = '{59,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};
    tbl[2]  = '{60,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[3]  = '{62,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'h123456};
    tbl[4]  = '{63,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h133659};
    tbl[5]  = '{67,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h173E65};
    tbl[6]  = '{68,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h184068};
    tbl[7]  = '{70,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[8]  = '{72,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};
    tbl[9]  = '{74,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};
    tbl[10] = '{75,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[11] = '{77,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h1A446E};
    tbl[12] = '{136, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[13] = '{137, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[14] = '{166, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[15] = '{167, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[16] = '{180, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[17] = '{182, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'h3274B6};

    // Reset held for 5 cycles with a non-empty FIFO.
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'd0);
    chk("rst_hs", 64'(vga_hs), 64'd1);
    chk("rst_vs", 64'(vga_vs), 64'd1);
    chk("rst_blank_n", 64'(vga_blank_n), 64'd0);
    chk("rst_frame_start", 64'(frame_start), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      at_cyc(tbl[i].k);
      chk($sformatf("tbl%0d_rd_en", tbl[i].k), 64'(fifo_rd_en), 64'(tbl[i].rd));
      chk($sformatf("tbl%0d_blank_n", tbl[i].k), 64'(vga_blank_n), 64'(tbl[i].blank_n));
      chk($sformatf("tbl%0d_hs", tbl[i].k), 64'(vga_hs), 64'(tbl[i].hs));
      chk($sformatf("tbl%0d_vs", tbl[i].k), 64'(vga_vs), 64'(tbl[i].vs));
      chk($sformatf("tbl%0d_fs", tbl[i].k), 64'(frame_start), 64'(tbl[i].fs));
      chk($sformatf("tbl%0d_rgb", tbl[i].k), 64'({vga_r, vga_g, vga_b}), 64'(tbl[i].rgb));
      snap[i] = dut_pops;
    end
    chk("pops_per_line", 64'(snap[10] - snap[2]), 64'd8);
    chk("pops_per_frame", 64'(snap[16] - snap[2]), 64'd32);

    // Three consecutive misses on line 0 of frame 2.
    wait_cyc(183);
    fifo_empty = 1'b1;
    @(negedge clk);
    #1;
    chk("miss_no_pop", 64'(fifo_rd_en), 64'd0);
    wait_cyc(186);
    fifo_empty = 1'b0;
    at_cyc(187);
    chk("miss_fill_rgb", 64'({vga_r, vga_g, vga_b}), 64'(FILL));
    chk("miss_underflow", 64'(underflow), 64'd1);
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("miss_cnt3", 64'(underflow_cnt), 64'd3);
`endif
    at_cyc(188);
    chk("after_miss_rgb", 64'({vga_r, vga_g, vga_b}), 64'h357ABF);
    at_cyc(199);
    chk("underflow_sticky", 64'(underflow), 64'd1);
    wait_cyc(200);
    underflow_clr = 1'b1;
    wait_cyc(201);
    underflow_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("underflow_cleared", 64'(underflow), 64'd0);
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("cnt_cleared", 64'(underflow_cnt), 64'd0);
`endif

    // Miss reaching the flag on the same edge as a clear: set wins.
    wait_cyc(210);
    fifo_empty = 1'b1;
    wait_cyc(211);
    fifo_empty = 1'b0;
    underflow_clr = 1'b1;
    wait_cyc(212);
    underflow_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("set_wins", 64'(underflow), 64'd1);
`ifdef VGA_UNDERFLOW_CNT_EN
    chk("cnt_set_and_clr", 64'(underflow_cnt), 64'd1);
`endif

    // Reset in the middle of an active line.
    at_cyc(227);
    chk("pre_rst_pop", 64'(fifo_rd_en), 64'd1);
    wait_cyc(228);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_no_pop", 64'(fifo_rd_en), 64'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_rgb", 64'({vga_r, vga_g, vga_b}), 64'd0);
    chk("mid_rst_blank_n", 64'(vga_blank_n), 64'd0);
    chk("mid_rst_hs", 64'(vga_hs), 64'd1);
    chk("mid_rst_vs", 64'(vga_vs), 64'd1);
    chk("mid_rst_fs", 64'(frame_start), 64'd0);
    chk("mid_rst_underflow", 64'(underflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pops_at_rel = dut_pops;
    at_cyc(59);
    chk("rerel_no_early_pop", 64'(dut_pops - pops_at_rel), 64'd0);
    at_cyc(60);
    chk("rerel_first_pop", 64'(fifo_rd_en), 64'd1);
    at_cyc(62);
    chk("rerel_frame_start", 64'(frame_start), 64'd1);
    chk("rerel_blank_n", 64'(vga_blank_n), 64'd1);
    at_cyc(130);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_out.md
# vga_scan_out

Downstream consumer of the VGA pixel FIFO. Generates VGA horizontal and vertical timing, one pixel per `clk`. Pops one 24-bit RGB pixel from the FIFO for every active-area pixel and drives registered RGB, sync and blank outputs. A missing pixel (FIFO empty) is replaced with a fill colour and recorded in an underflow flag.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, sync asserted level (0 = active-low syncs)
- `FILL_COLOR`, 24'h000000, RGB driven for an underflowed pixel

Ports:
- `clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-low reset
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_data`  in  24  FIFO `data_pixel`, valid the cycle after a pop
- `fifo_rd_en`  out  1  FIFO pop request
- `underflow_clr`  in  1  clears `underflow`
- `vga_r`, `vga_g`, `vga_b`  out  8 each  colour, from `{R,G,B}` = `fifo_data[23:16]`, `[15:8]`, `[7:0]`
- `vga_hs`, `vga_vs`  out  1  sync outputs
- `vga_blank_n`  out  1  high during the active area
- `frame_start`  out  1  one-cycle pulse on the first active pixel of each frame
- `underflow`  out  1  sticky: an active pixel was not available

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800); `V_TOTAL` (525).
- Counters: `h_cnt` runs 0..`H_TOTAL-1` and wraps to 0. `v_cnt` increments when `h_cnt` wraps and wraps 0 after `V_TOTAL-1`.
- Widths: both counters are 11 bits. Compare with equality against `TOTAL-1`; never overflow the counter width.
- Active region: `act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`.
- Pop request: `fifo_rd_en = rst && act && !fifo_empty`. This is combinational from the counter registers and `fifo_empty`. Never pop outside the active region.
- Pipeline stage 1 (registered): delays `act`, `miss = act && fifo_empty`, the hs/vs terms and the first-pixel term.
- Pipeline stage 2 (output registers):
  - RGB = `fifo_data` if the stage-1 pop occurred.
  - RGB = `FILL_COLOR` if the stage-1 `miss` is set.
  - RGB = 0 if the stage-1 `act` is low (blanking).
- hs asserted for `h_cnt` in [`H_ACTIVE+H_FP`, `H_ACTIVE+H_FP+H_SYNC`), i.e. 656..751. vs asserted for `v_cnt` in [490, 492). Both are delayed so they stay aligned with RGB.
- `frame_start` corresponds to `h_cnt==0 && v_cnt==0` and is aligned with RGB.
- `underflow` is set by a stage-1 miss and cleared by `underflow_clr`. If a set and a clear occur in the same cycle, set wins.

## Timing
- Pixel latency: pop at cycle t (counter position P) → `fifo_data` valid during t+1 → `vga_*` registered at edge t+2. Sync, blank and `frame_start` carry the same 2-cycle lag relative to the counters.
- Reset (while `rst`=0, sampled at posedge):
  - `h_cnt`=0, `v_cnt`=`V_ACTIVE` (start of the vertical front porch), pipeline cleared.
  - `fifo_rd_en`=0, RGB=0, `vga_blank_n`=0, `frame_start`=0, `underflow`=0.
  - `vga_hs` = `vga_vs` = `!SYNC_POL`, i.e. deasserted.
- After reset the first active pixel is popped `(V_TOTAL-V_ACTIVE)*H_TOTAL` = 36000 cycles after `rst` rises. This gives the upstream time to fill the FIFO.
- Reset mid-line: timing restarts from the reset position on the next cycle. Any in-flight pixel is discarded and not displayed.
- FIFO empty mid-line: that pixel is shown as `FILL_COLOR` and is not retried. Later pixels pop normally once the FIFO is non-empty, so the image shifts; recovery is at the next frame.
- No pops occur during blanking, even when the FIFO is full.

## Configuration
- `VGA_UNDERFLOW_CNT_EN` defined:
  - Adds output `underflow_cnt [15:0]`.
  - The counter increments once per missed active pixel and saturates at 16'hFFFF.
  - It is reset to 0 by `rst` and by `underflow_clr`. If a miss and a clear occur in the same cycle, the result is 1.
- `VGA_UNDERFLOW_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: hold `rst`=0 for 5 cycles with `fifo_empty`=0.
  - Response: `fifo_rd_en`=0, RGB=0, `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, `underflow`=0.
- First pop:
  - Stimulus: release reset with the FIFO kept non-empty.
  - Response: the first `fifo_rd_en` occurs exactly 36000 cycles later. `frame_start` pulses 2 cycles after that pop, with `vga_blank_n`=1.
- Data path:
  - Stimulus: `fifo_data`=24'h123456 returned after a pop.
  - Response: `vga_r`=8'h12, `vga_g`=8'h34, `vga_b`=8'h56 two cycles after the pop. Exactly 640 pops per active line; 307200 per frame.
- Sync:
  - Response: `vga_hs` low for 96 cycles starting 656 cycles after each line's first active output. `vga_vs` low for 1600 cycles per 420000-cycle frame.
- Underflow:
  - Stimulus: force `fifo_empty`=1 for 3 active pixels.
  - Response: no pop on those cycles; RGB=`FILL_COLOR` for 3 outputs; `underflow` sticks at 1. `underflow_cnt`=3 when `VGA_UNDERFLOW_CNT_EN` is defined. Pulse `underflow_clr` → `underflow` returns to 0.
- Mid-operation reset:
  - Stimulus: assert `rst`=0 at `h_cnt`=300 of an active line.
  - Response: one cycle later all outputs are at their reset values, and no further pops occur until 36000 cycles after release.
